regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register bank and shares it among NREQ writeback requesters (ALU, load unit, link/JAL path) with valid/ready handshakes and round-robin arbitration.
- After reset, optionally sweeps zeros into registers 1..31 through the same port before accepting traffic.
- Sits between the writeback stage and the register bank; its outputs connect directly to the bank's WriteAddr/WriteData/RegWrite.

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register bank write port, with optional zero sweep after reset.
// Optional WB_STATS_EN adds saturating write/drop counters (stat_writes, stat_drops).
module regfile_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter bit INIT_SWEEP = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [4:0]           WriteAddr,
    output logic [31:0]          WriteData,
    output logic                 RegWrite,
    output logic                 init_done,
    output logic                 zero_drop,
    output logic                 dbg_state_o
`ifdef WB_STATS_EN
    ,
    output logic [15:0]          stat_writes,
    output logic [15:0]          stat_drops
`endif
);

    localparam int RRW = (NREQ > 2) ? 2 : 1;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t         state_q;
    logic [4:0]     cnt_q;
    logic [RRW-1:0] rr_q;
    logic [4:0]     waddr_q;
    logic [31:0]    wdata_q;
    logic           regwrite_q;
    logic           init_done_q;
    logic           zero_drop_q;
`ifdef WB_STATS_EN
    logic [15:0]    stat_writes_q;
    logic [15:0]    stat_drops_q;
`endif

    logic           grant_any;
    logic [RRW-1:0] grant_idx;
    logic [RRW-1:0] idx;
    int             slot;
    logic [4:0]     sel_addr;
    logic [31:0]    sel_data;

    // Handshake: a transfer happens on a rising edge where req_valid[i] && req_ready[i];
    // a requester keeps valid/addr/data stable until it sees ready, and ready never waits on anything
    // but valid, rr_q and state_q.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        slot      = 0;
        req_ready = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                slot = int'(rr_q) + k;
                if (slot >= NREQ) slot = slot - NREQ;
                idx = slot[RRW-1:0];
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (grant_any) req_ready[grant_idx] = 1'b1;
        sel_addr = req_addr[grant_idx*5 +: 5];
        sel_data = req_data[grant_idx*32 +: 32];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= INIT_SWEEP ? ST_INIT : ST_RUN;
            cnt_q       <= 5'd1;
            rr_q        <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            regwrite_q  <= 1'b0;
            zero_drop_q <= 1'b0;
            init_done_q <= !INIT_SWEEP;
`ifdef WB_STATS_EN
            stat_writes_q <= '0;
            stat_drops_q  <= '0;
`endif
        end else if (state_q == ST_INIT) begin
            regwrite_q  <= 1'b1;
            waddr_q     <= cnt_q;
            wdata_q     <= '0;
            zero_drop_q <= 1'b0;
            // The counter parks at 31 so it never wraps back into register 0.
            if (cnt_q == 5'd31) begin
                state_q     <= ST_RUN;
                init_done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end else begin
            regwrite_q  <= 1'b0;
            zero_drop_q <= 1'b0;
            if (grant_any) begin
                if (grant_idx == RRW'(NREQ - 1)) rr_q <= '0;
                else                             rr_q <= grant_idx + 1'b1;
                if (sel_addr != 5'd0) begin
                    regwrite_q <= 1'b1;
                    waddr_q    <= sel_addr;
                    wdata_q    <= sel_data;
`ifdef WB_STATS_EN
                    if (stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
`endif
                end else begin
                    zero_drop_q <= 1'b1;
`ifdef WB_STATS_EN
                    if (stat_drops_q != 16'hFFFF) stat_drops_q <= stat_drops_q + 16'd1;
`endif
                end
            end
        end
    end

    assign WriteAddr   = waddr_q;
    assign WriteData   = wdata_q;
    assign RegWrite    = regwrite_q;
    assign init_done   = init_done_q;
    assign zero_drop   = zero_drop_q;
    assign dbg_state_o = (state_q == ST_RUN);
`ifdef WB_STATS_EN
    assign stat_writes = stat_writes_q;
    assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, INIT_SWEEP=1): sweep, round-robin, reg-0 drop,
// mid-sweep reset, and counter saturation when WB_STATS_EN is defined.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        init_done;
  logic        zero_drop;
  logic        dbg_state;
`ifdef WB_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_drops;
`endif

  regfile_wb_arbiter #(.NREQ(3), .INIT_SWEEP(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .WriteAddr(WriteAddr),
    .WriteData(WriteData),
    .RegWrite(RegWrite),
    .init_done(init_done),
    .zero_drop(zero_drop),
    .dbg_state_o(dbg_state)
`ifdef WB_STATS_EN
    ,
    .stat_writes(stat_writes),
    .stat_drops(stat_drops)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected bank writes, plus a bank image built from observed writes
  logic [36:0] exp_q[$];
  logic [31:0] bank[32];
  logic        mon_en = 1'b0;

  always @(negedge clock) begin
    if (RegWrite) bank[WriteAddr] = WriteData;
    if (mon_en && RegWrite) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_write: got %0h:%0h expected none", WriteAddr, WriteData);
      end else begin
        check("sb_write", {WriteAddr, WriteData}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic sweep(input int n);
    for (int k = 1; k <= n; k++) begin
      #1;
      check("sweep_ready", req_ready, 3'b000);
      check("sweep_init_low", init_done, 1'b0);
      @(negedge clock);
      check("sweep_we", RegWrite, 1'b1);
      check("sweep_addr", WriteAddr, k[4:0]);
      check("sweep_data", WriteData, 32'h0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_we", RegWrite, 1'b0);
    check("rst_addr", WriteAddr, 5'd0);
    check("rst_data", WriteData, 32'h0);
    check("rst_zd", zero_drop, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_state", dbg_state, 1'b0);
`ifdef WB_STATS_EN
    check("rst_stat_writes", stat_writes, 16'h0);
    check("rst_stat_drops", stat_drops, 16'h0);
`endif
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        zd;
  } vec_t;

  vec_t vecs[12];
  int   exp_writes;
  int   exp_drops;

  initial begin
    vecs[0]  = '{3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 3'b001, 1'b1, 5'd5, 32'hA, 1'b0};
    vecs[1]  = '{3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 3'b010, 1'b1, 5'd6, 32'hB, 1'b0};
    vecs[2]  = '{3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 3'b100, 1'b1, 5'd7, 32'hC, 1'b0};
    vecs[3]  = '{3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 3'b001, 1'b1, 5'd5, 32'hA, 1'b0};
    vecs[4]  = '{3'b000, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 3'b000, 1'b0, 5'd5, 32'hA, 1'b0};
    vecs[5]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b0, 5'd5, 32'hA, 1'b1};
    vecs[6]  = '{3'b101, 5'd9, 5'd0, 5'd9, 32'h11, 32'h0, 32'h22, 3'b100, 1'b1, 5'd9, 32'h22, 1'b0};
    vecs[7]  = '{3'b101, 5'd9, 5'd0, 5'd9, 32'h11, 32'h0, 32'h22, 3'b001, 1'b1, 5'd9, 32'h11, 1'b0};
    vecs[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd9, 32'h11, 1'b0};
    vecs[9]  = '{3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0, 3'b001, 1'b1, 5'd4, 32'h44, 1'b0};
    vecs[10] = '{3'b011, 5'd4, 5'd8, 5'd0, 32'h55, 32'h88, 32'h0, 3'b010, 1'b1, 5'd8, 32'h88, 1'b0};
    vecs[11] = '{3'b011, 5'd4, 5'd8, 5'd0, 32'h55, 32'h88, 32'h0, 3'b001, 1'b1, 5'd4, 32'h55, 1'b0};

    reset = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", req_ready, 3'b000);
    check_reset_outputs();

    // Sweep with all requesters pending: nothing may be granted until RUN.
    drive(3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC);
    reset = 1'b1;
    sweep(31);
    check("post_sweep_init_done", init_done, 1'b1);
    check("post_sweep_state", dbg_state, 1'b1);
    #1;
    check("first_grant", req_ready, 3'b001);

    mon_en     = 1'b1;
    exp_writes = 0;
    exp_drops  = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      #1;
      check($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
      if (vecs[i].we) begin
        exp_q.push_back({vecs[i].waddr, vecs[i].wdata});
        exp_writes++;
      end
      if (vecs[i].zd) exp_drops++;
      @(negedge clock);
      check($sformatf("v%0d_we", i), RegWrite, vecs[i].we);
      check($sformatf("v%0d_waddr", i), WriteAddr, vecs[i].waddr);
      check($sformatf("v%0d_wdata", i), WriteData, vecs[i].wdata);
      check($sformatf("v%0d_zd", i), zero_drop, vecs[i].zd);
    end
    #1;
    mon_en = 1'b0;
    check("sb_queue_empty", exp_q.size(), 0);
    check("bank_r9_last_writer", bank[9], 32'h11);
`ifdef WB_STATS_EN
    check("stat_writes_table", stat_writes, exp_writes);
    check("stat_drops_table", stat_drops, exp_drops);
`endif

    // Reset pulled low for one edge in the middle of the sweep restarts it from register 1.
    drive(3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sweep(10);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("midrst_ready", req_ready, 3'b000);
    check_reset_outputs();
    reset = 1'b1;
    sweep(31);
    check("resweep_init_done", init_done, 1'b1);
    #1;
    check("resweep_first_grant", req_ready, 3'b001);

`ifdef WB_STATS_EN
    drive(3'b001, 5'd3, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0);
    repeat (70000) @(negedge clock);
    check("stat_writes_saturated", stat_writes, 16'hFFFF);
    check("stat_drops_unchanged", stat_drops, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
